// File: rtl/db_pipe_pkg.sv
// Shared definitions for the db_pipe_reg pipeline register and its stages.
// The occupancy counter (macro DB_PIPE_OCCUPANCY_EN) sizes itself with occ_width().
package db_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 32'd8;
  localparam int unsigned DEFAULT_DEPTH     = 32'd4;
  localparam logic        DEFAULT_RESET_BIT = 1'b0;

  // Enough bits to count from 0 up to and including depth.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/db_pipe_chk.sv
// Assertion checker: the occupancy counter always equals the number of valid stages.
// Instantiated by db_pipe_reg only when DB_PIPE_OCCUPANCY_EN is defined.
module db_pipe_chk
  import db_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [DEPTH-1:0]             i_valid_vec,
  input  logic [occ_width(DEPTH)-1:0]  i_occ
);

  a_occ_matches_valid: assert property (@(posedge i_clk) disable iff (i_reset)
    int'(i_occ) == $countones(i_valid_vec));

  a_occ_bounded: assert property (@(posedge i_clk) disable iff (i_reset)
    int'(i_occ) <= int'(DEPTH));

endmodule

// File: rtl/db_pipe_stage.sv
// One pipeline stage: a {valid, data} register with sync reset, flush and enable.
// Flush clears only the valid bit so the data contents survive.
module db_pipe_stage
  import db_pipe_pkg::*;
#(
  parameter int unsigned       WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t r_stage;

  // Stage register: reset > flush > enable > hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stage.valid <= 1'b0;
      r_stage.data  <= RESET_VAL;
    end else if (i_flush) begin
      r_stage.valid <= 1'b0;
      r_stage.data  <= r_stage.data;
    end else if (i_en) begin
      r_stage.valid <= i_valid;
      r_stage.data  <= i_data;
    end else begin
      r_stage <= r_stage;
    end
  end

  assign o_valid = r_stage.valid;
  assign o_data  = r_stage.data;

endmodule

// File: rtl/db_pipe_reg.sv
// DEPTH-stage, WIDTH-bit pipeline register with per-stage valid, stall and flush.
// Define DB_PIPE_OCCUPANCY_EN to add the occupancy output and its counter.
module db_pipe_reg
  import db_pipe_pkg::*;
#(
  parameter int unsigned       WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned       DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{DEFAULT_RESET_BIT}}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            d,
  input  logic                        d_valid,
`ifdef DB_PIPE_OCCUPANCY_EN
  output logic [occ_width(DEPTH)-1:0] occupancy,
`endif
  output logic [WIDTH-1:0]            q,
  output logic                        q_valid
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  if (DEPTH < 32'd1) begin : g_bad_depth
    $error("db_pipe_reg: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] w_valid;
  logic [WIDTH-1:0] w_data [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             w_in_valid;
    logic [WIDTH-1:0] w_in_data;

    if (g == 0) begin : g_head
      assign w_in_valid = d_valid;
      assign w_in_data  = d;
    end else begin : g_body
      assign w_in_valid = w_valid[g-1];
      assign w_in_data  = w_data[g-1];
    end

    db_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .i_clk   (clk),
      .i_reset (reset),
      .i_flush (flush),
      .i_en    (en),
      .i_valid (w_in_valid),
      .i_data  (w_in_data),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g])
    );
  end

  assign q       = w_data[DEPTH-1];
  assign q_valid = w_valid[DEPTH-1];

`ifdef DB_PIPE_OCCUPANCY_EN
  logic [OCC_W-1:0] r_occ;

  // Entry and exit on the same edge cancel; modular arithmetic keeps this exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= {OCC_W{1'b0}};
    end else if (flush) begin
      r_occ <= {OCC_W{1'b0}};
    end else if (en) begin
      r_occ <= r_occ + OCC_W'(d_valid) - OCC_W'(q_valid);
    end else begin
      r_occ <= r_occ;
    end
  end

  assign occupancy = r_occ;

  db_pipe_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_valid_vec (w_valid),
    .i_occ       (r_occ)
  );
`endif

endmodule

// File: tb/tb_db_pipe_reg.sv
// Self-checking bench for db_pipe_reg: DEPTH=4/WIDTH=8 and DEPTH=1/WIDTH=16 side by side.
// Reference model is a per-enabled-edge history log; occupancy checked with DB_PIPE_OCCUPANCY_EN.
module tb_db_pipe_reg;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic [15:0] d;
  logic        d_valid;

  logic [7:0]  q0;
  logic        qv0;
  logic [15:0] q1;
  logic        qv1;
`ifdef DB_PIPE_OCCUPANCY_EN
  logic [2:0]  occ0;
  logic [0:0]  occ1;
`endif

  int n_chk;
  int n_err;

  db_pipe_reg #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .d         (d[7:0]),
    .d_valid   (d_valid),
`ifdef DB_PIPE_OCCUPANCY_EN
    .occupancy (occ0),
`endif
    .q         (q0),
    .q_valid   (qv0)
  );

  db_pipe_reg #(.WIDTH(16), .DEPTH(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .d         (d),
    .d_valid   (d_valid),
`ifdef DB_PIPE_OCCUPANCY_EN
    .occupancy (occ1),
`endif
    .q         (q1),
    .q_valid   (qv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // History of accepted beats per DUT, one entry per enabled edge; output is DEPTH back.
  logic [15:0] hd [2][$];
  logic        hv [2][$];
  int          dep [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic fl, input logic e,
                            input logic dv, input logic [15:0] dd);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        for (int j = 0; j < dep[k]; j++) begin
          hd[k][hd[k].size() - 1 - j] = 16'h0000;
          hv[k][hv[k].size() - 1 - j] = 1'b0;
        end
      end else if (fl) begin
        for (int j = 0; j < dep[k]; j++) hv[k][hv[k].size() - 1 - j] = 1'b0;
      end else if (e) begin
        hd[k].push_back((k == 0) ? {8'h00, dd[7:0]} : dd);
        hv[k].push_back(dv);
      end
    end
  endtask

  function automatic logic [15:0] exp_q(input int k);
    return hd[k][hd[k].size() - dep[k]];
  endfunction

  function automatic logic exp_qv(input int k);
    return hv[k][hv[k].size() - dep[k]];
  endfunction

  function automatic int exp_occ(input int k);
    int c = 0;
    for (int j = 0; j < dep[k]; j++) c += int'(hv[k][hv[k].size() - 1 - j]);
    return c;
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    model_edge(reset, flush, en, d_valid, d);
    #1;
    check_eq("q_d4",  32'(q0),  32'(exp_q(0)));
    check_eq("qv_d4", 32'(qv0), 32'(exp_qv(0)));
    check_eq("q_d1",  32'(q1),  32'(exp_q(1)));
    check_eq("qv_d1", 32'(qv1), 32'(exp_qv(1)));
`ifdef DB_PIPE_OCCUPANCY_EN
    check_eq("occ_d4", 32'(occ0), 32'(exp_occ(0)));
    check_eq("occ_d1", 32'(occ1), 32'(exp_occ(1)));
`endif
  endtask

  task automatic drive(input logic e, input logic dv, input logic [15:0] dd);
    en = e; d_valid = dv; d = dd;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    dep[0] = 4;
    dep[1] = 1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < dep[k]; j++) begin
        hd[k].push_back(16'h0000);
        hv[k].push_back(1'b0);
      end
    end
    reset = 1'b1; flush = 1'b0;
    drive(1'b1, 1'b1, 16'h00FF);

    // Reset held two cycles with live input
    step(); step();
    check_eq("rst_q",  32'(q0),  32'h00);
    check_eq("rst_qv", 32'(qv0), 32'h0);
`ifdef DB_PIPE_OCCUPANCY_EN
    check_eq("rst_occ", 32'(occ0), 32'h0);
`endif
    reset = 1'b0;

    // Latency with three back-to-back beats
    drive(1'b1, 1'b1, 16'h00A1); step();
    drive(1'b1, 1'b1, 16'h00A2); step();
    drive(1'b1, 1'b1, 16'h00A3); step();
    drive(1'b1, 1'b0, 16'h0000); step();
    check_eq("lat_a1", 32'({qv0, q0}), 32'h1A1);
    step(); check_eq("lat_a2", 32'({qv0, q0}), 32'h1A2);
    step(); check_eq("lat_a3", 32'({qv0, q0}), 32'h1A3);
    step(); check_eq("lat_end", 32'(qv0), 32'h0);

    // Stall for three cycles after A2 enters
    drive(1'b1, 1'b1, 16'h00A1); step();
    drive(1'b1, 1'b1, 16'h00A2); step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 16'h00EE); step();
      check_eq("stall_qv", 32'(qv0), 32'h0);
    end
    drive(1'b1, 1'b1, 16'h00A3); step();
    drive(1'b1, 1'b0, 16'h0000); step();
    check_eq("stall_a1", 32'({qv0, q0}), 32'h1A1);
    step(); check_eq("stall_a2", 32'({qv0, q0}), 32'h1A2);
    step(); check_eq("stall_a3", 32'({qv0, q0}), 32'h1A3);

    // Bubble in the middle of a burst
    drive(1'b1, 1'b1, 16'h0011); step();
    drive(1'b1, 1'b0, 16'h0022); step();
    drive(1'b1, 1'b1, 16'h0033); step();
    drive(1'b1, 1'b0, 16'h0000); step();
    check_eq("bub_11", 32'({qv0, q0}), 32'h111);
    step(); check_eq("bub_gap", 32'(qv0), 32'h0);
    step(); check_eq("bub_33", 32'({qv0, q0}), 32'h133);

    // Flush with three items in flight drops them and the same-cycle beat
    drive(1'b1, 1'b1, 16'h0001); step();
    drive(1'b1, 1'b1, 16'h0002); step();
    drive(1'b1, 1'b1, 16'h0003); step();
    flush = 1'b1;
    drive(1'b1, 1'b1, 16'h0055); step();
    flush = 1'b0;
    check_eq("flush_qv", 32'(qv0), 32'h0);
`ifdef DB_PIPE_OCCUPANCY_EN
    check_eq("flush_occ", 32'(occ0), 32'h0);
`endif
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 16'h0000); step();
      check_eq("flush_no55", 32'(qv0), 32'h0);
    end

    // Reset mid-stream loses in-flight items
    drive(1'b1, 1'b1, 16'h00C1); step();
    drive(1'b1, 1'b1, 16'h00C2); step();
    reset = 1'b1; step();
    reset = 1'b0;
    check_eq("mrst_q", 32'({qv0, q0}), 32'h000);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0000); step();
      check_eq("mrst_qv", 32'(qv0), 32'h0);
    end

    // Single-stage, 16-bit instance
    drive(1'b1, 1'b1, 16'hBEEF); step();
    check_eq("d1_beef", 32'({qv1, q1}), 32'h1BEEF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(99) < 2);
      flush   = ($urandom_range(99) < 4);
      drive(($urandom_range(99) < 75), $urandom_range(1), 16'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
